vga_timing_gen: RTL

//   Generates VGA 640x480@60 raster timing: free-running X_VGA/Y_VGA counters, sync, blank and pixel strobe.

---
 rtl/vga_timing_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator, 640x480@60 by default. Free-running
//   full-raster X/Y counters (sync and porches included, so the visible area
//   starts at X = H_SYNC+H_BACK, Y = V_SYNC+V_BACK). The generator also
//   produces sync, blank, the DAC pixel clock and one-cycle pixel/line/frame
//   strobes that pace the downstream sprite-buffer stages.
//
// Ports
//   CLK          in   system clock (single domain)
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = raster runs, 0 = freeze (counters hold, strobes low)
//   X_VGA        out  raster column 0..H_TOTAL-1
//   Y_VGA        out  raster line   0..V_TOTAL-1
//   X_ATIVO      out  column relative to the active area, 0 outside it
//   Y_ATIVO      out  line relative to the active area, 0 outside it
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  1 inside the active area
//   VGA_SYNC_N   out  constant 0 (composite sync unused)
//   VGA_CLK      out  pixel clock, high for the first half of each pixel period
//   PIXEL_TICK   out  one-CLK pulse after every raster advance
//   LINE_START   out  one-CLK pulse when X wrapped to 0
//   FRAME_START  out  one-CLK pulse when X and Y both wrapped to 0
//
// Every output except VGA_SYNC_N is a flop; the decode is done on the next
// counter values so each output is coherent with X_VGA/Y_VGA in the same cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] X_VGA,
  output logic [9:0] Y_VGA,
  output logic [9:0] X_ATIVO,
  output logic [9:0] Y_ATIVO,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       PIXEL_TICK,
  output logic       LINE_START,
  output logic       FRAME_START
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Divider width: a 1-bit counter is kept even for CLK_DIV=1 (it stays at 0).
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // VGA_CLK high while div < ceil(CLK_DIV/2); one extra bit so the constant
  // always fits regardless of CLK_DIV.
  localparam logic [DIV_W:0]   DIV_HALF = (DIV_W + 1)'((CLK_DIV + 1) / 2);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds are compared in 11 bits: an active area ending exactly at
  // a 1024-wide raster would not fit the 10-bit counter range.
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA_BEG = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] VA_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] HA_END = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] VA_END = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  HA_OFS = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  VA_OFS = 10'(V_SYNC + V_BACK);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [9:0]       x_ativo_q, x_ativo_d;
  logic [9:0]       y_ativo_q, y_ativo_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic             vga_clk_q, vga_clk_d;
  logic             pixel_tick_q, pixel_tick_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic tick;
  logic x_wrap;
  logic y_wrap;
  logic h_active;
  logic v_active;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    div_d    = div_q;
    tick     = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    x_wrap   = (x_q == H_LAST);
    y_wrap   = (y_q == V_LAST);

    // Freezing clears the divider so a resume waits a full pixel period.
    if (!enable) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      tick  = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (tick) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decode from the next counter values so the registered outputs line up
    // with X_VGA/Y_VGA. When not ticking x_d/y_d equal the held values.
    hs_d      = ({1'b0, x_d} >= HS_END);
    vs_d      = ({1'b0, y_d} >= VS_END);
    h_active  = ({1'b0, x_d} >= HA_BEG) && ({1'b0, x_d} < HA_END);
    v_active  = ({1'b0, y_d} >= VA_BEG) && ({1'b0, y_d} < VA_END);
    blank_n_d = h_active && v_active;
    x_ativo_d = blank_n_d ? (x_d - HA_OFS) : '0;
    y_ativo_d = blank_n_d ? (y_d - VA_OFS) : '0;

    vga_clk_d     = enable && ({1'b0, div_d} < DIV_HALF);
    pixel_tick_d  = tick;
    line_start_d  = tick && x_wrap;
    frame_start_d = tick && x_wrap && y_wrap;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      x_ativo_q     <= '0;
      y_ativo_q     <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      blank_n_q     <= 1'b0;
      vga_clk_q     <= 1'b0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      x_ativo_q     <= x_ativo_d;
      y_ativo_q     <= y_ativo_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      vga_clk_q     <= vga_clk_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign X_VGA       = x_q;
  assign Y_VGA       = y_q;
  assign X_ATIVO     = x_ativo_q;
  assign Y_ATIVO     = y_ativo_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = vga_clk_q;
  assign PIXEL_TICK  = pixel_tick_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

endmodule
